// File: rtl/ts_packet_mux.sv
// ts_packet_mux: round-robin multiplexer of N transport-stream sources onto one byte stream.
// Each granted packet is a header read from an external RAM followed by the channel's payload.
module ts_packet_mux #(
  parameter int          N_CH      = 4,
  parameter int          HDR_BYTES = 4,
  parameter int          PKT_BYTES = 188,
  parameter logic [7:0]  SYNC_BYTE = 8'h47,
  localparam int         CW        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int         HW        = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1
) (
  input  logic                 SYS_CLK,
  input  logic                 RST,
  input  logic [N_CH-1:0]      GOT_FULL_PACKET,
  input  logic [N_CH-1:0]      CH_ENABLE,
  input  logic [8*N_CH-1:0]    DATA_IN_BUS,
  output logic [CW+HW-1:0]     HDR_ADDR,
  input  logic [7:0]           HDR_BYTE,
  output logic [N_CH-1:0]      RD_REQ,
  input  logic                 OUT_READY,
  output logic [7:0]           DATA_OUT,
  output logic                 D_VALID_OUT,
  output logic                 SOP_OUT,
  output logic                 P_SYNC_OUT,
  output logic                 SYNC_ERR,
  output logic [1:0]           STATE_MON
);

  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_HEADER  = 2'd1;
  localparam logic [1:0]    S_PAYLOAD = 2'd2;
  localparam logic [7:0]    HDR_LAST  = 8'(HDR_BYTES - 1);
  localparam logic [7:0]    PKT_LAST  = 8'(PKT_BYTES - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

  logic [1:0]      state_r;
  logic [CW-1:0]   chan_r;
  logic [CW-1:0]   rr_ptr_r;
  logic [7:0]      cnt_r;
  logic            sync_err_r;

  logic [N_CH-1:0] eligible_s;
  logic [CW-1:0]   grant_ch_s;
  logic [CW-1:0]   next_ptr_s;
  logic [7:0]      ch_byte_s;
  int              cand_s;

  assign eligible_s = GOT_FULL_PACKET & CH_ENABLE;
  assign next_ptr_s = (chan_r == CH_LAST) ? {CW{1'b0}} : (chan_r + CW'(1'b1));
  assign STATE_MON  = state_r;
  assign SYNC_ERR   = sync_err_r;

  // Round-robin pick: scan downward so the candidate closest to rr_ptr overwrites last.
  always_comb begin
    grant_ch_s = rr_ptr_r;
    cand_s     = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand_s     = int'(rr_ptr_r) + i;
      cand_s     = (cand_s >= N_CH) ? (cand_s - N_CH) : cand_s;
      grant_ch_s = eligible_s[cand_s[CW-1:0]] ? cand_s[CW-1:0] : grant_ch_s;
    end
  end

  // Byte currently presented by the granted channel's show-ahead FIFO.
  always_comb begin
    ch_byte_s = 8'h00;
    for (int c = 0; c < N_CH; c++) begin
      ch_byte_s = (chan_r == CW'(c)) ? DATA_IN_BUS[8*c +: 8] : ch_byte_s;
    end
  end

  // Output stream and FIFO read strobe decode from the current state.
  always_comb begin
    DATA_OUT    = 8'h00;
    D_VALID_OUT = 1'b0;
    SOP_OUT     = 1'b0;
    P_SYNC_OUT  = 1'b0;
    RD_REQ      = {N_CH{1'b0}};
    HDR_ADDR    = {rr_ptr_r, {HW{1'b0}}};
    case (state_r)
      S_HEADER: begin
        HDR_ADDR    = {chan_r, cnt_r[HW-1:0]};
        DATA_OUT    = HDR_BYTE;
        D_VALID_OUT = 1'b1;
        SOP_OUT     = (cnt_r == 8'd0);
      end
      S_PAYLOAD: begin
        HDR_ADDR       = {chan_r, {HW{1'b0}}};
        DATA_OUT       = ch_byte_s;
        D_VALID_OUT    = 1'b1;
        P_SYNC_OUT     = (cnt_r == 8'd0);
        RD_REQ[chan_r] = OUT_READY;
      end
      default: begin
        HDR_ADDR = {rr_ptr_r, {HW{1'b0}}};
      end
    endcase
  end

  // Packet sequencer; a granted packet always runs to completion.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= S_IDLE;
      chan_r   <= {CW{1'b0}};
      rr_ptr_r <= {CW{1'b0}};
      cnt_r    <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (|eligible_s) begin
            chan_r  <= grant_ch_s;
            cnt_r   <= 8'd0;
            state_r <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (OUT_READY) begin
            if (cnt_r == HDR_LAST) begin
              cnt_r   <= 8'd0;
              state_r <= S_PAYLOAD;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (OUT_READY) begin
            if (cnt_r == PKT_LAST) begin
              cnt_r    <= 8'd0;
              rr_ptr_r <= next_ptr_s;
              state_r  <= S_IDLE;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Flags a bad sync byte the cycle after payload byte 0 is accepted downstream.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      sync_err_r <= 1'b0;
    end else begin
      sync_err_r <= (state_r == S_PAYLOAD) && (cnt_r == 8'd0) && OUT_READY && (ch_byte_s != SYNC_BYTE);
    end
  end

endmodule

// File: tb/tb_ts_packet_mux.sv
// Testbench for ts_packet_mux: FIFO/header-RAM models feed a default 4-channel instance
// whose output is scored against a queue; a 3-channel instance covers the small configuration.
module tb_ts_packet_mux;
  localparam int PKT = 188;
  localparam int HDR = 4;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  got, en, rd_req, hdr_addr;
  logic [31:0] din;
  logic [7:0]  hdr_byte, data_out;
  logic        out_ready, d_valid, sop, psync, sync_err;
  logic [1:0]  state_mon;

  logic [2:0]  got_b, en_b, rd_req_b, hdr_addr_b;
  logic [23:0] din_b;
  logic [7:0]  hdr_byte_b, data_out_b;
  logic        ready_b, d_valid_b, sop_b, psync_b, sync_err_b;
  logic [1:0]  state_mon_b;

  int          n_cmp = 0, n_err = 0;
  logic [9:0]  sb[$];
  int          sop_cyc[$];
  int          ptr[4];
  int          exp_pkt[4];
  int          rd_cnt[4];
  int          vcnt = 0, serr_cnt = 0, cyc = 0;
  int          bad_ch = -1, bad_pkt = -1;
  logic        prev_bad = 1'b0;

  ts_packet_mux #(.N_CH(4), .HDR_BYTES(HDR), .PKT_BYTES(PKT), .SYNC_BYTE(8'h47)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_PACKET(got), .CH_ENABLE(en), .DATA_IN_BUS(din),
    .HDR_ADDR(hdr_addr), .HDR_BYTE(hdr_byte), .RD_REQ(rd_req), .OUT_READY(out_ready),
    .DATA_OUT(data_out), .D_VALID_OUT(d_valid), .SOP_OUT(sop), .P_SYNC_OUT(psync),
    .SYNC_ERR(sync_err), .STATE_MON(state_mon));

  ts_packet_mux #(.N_CH(3), .HDR_BYTES(2), .PKT_BYTES(10), .SYNC_BYTE(8'h47)) dut_b (
    .SYS_CLK(SYS_CLK), .RST(RST), .GOT_FULL_PACKET(got_b), .CH_ENABLE(en_b), .DATA_IN_BUS(din_b),
    .HDR_ADDR(hdr_addr_b), .HDR_BYTE(hdr_byte_b), .RD_REQ(rd_req_b), .OUT_READY(ready_b),
    .DATA_OUT(data_out_b), .D_VALID_OUT(d_valid_b), .SOP_OUT(sop_b), .P_SYNC_OUT(psync_b),
    .SYNC_ERR(sync_err_b), .STATE_MON(state_mon_b));

  always #5 SYS_CLK = ~SYS_CLK;

  function automatic logic [7:0] pay_byte(input int c, input int p, input int k, input int bc, input int bp);
    if (k == 0) return (c == bc && p == bp) ? 8'h46 : 8'h47;
    return 8'(k + 16 * c + p);
  endfunction

  // Header RAM contents: 0x80 + 16*channel + index.
  assign hdr_byte   = 8'h80 + {2'b00, hdr_addr[3:2], 4'h0} + {6'h00, hdr_addr[1:0]};
  assign hdr_byte_b = 8'h80 + {2'b00, hdr_addr_b[2:1], 4'h0} + {7'h00, hdr_addr_b[0]};
  assign din_b      = {3{8'h47}};

  always_comb begin
    for (int c = 0; c < 4; c++) din[8*c +: 8] = pay_byte(c, ptr[c] / PKT, ptr[c] % PKT, bad_ch, bad_pkt);
  end

  // Source FIFOs: reads advance; under reset upstream flushes to the next packet boundary.
  always @(posedge SYS_CLK) begin
    for (int c = 0; c < 4; c++) begin
      if (!RST) ptr[c] <= ((ptr[c] + PKT - 1) / PKT) * PKT;
      else if (rd_req[c]) ptr[c] <= ptr[c] + 1;
    end
  end

  task automatic push_pkt(input int c);
    int p;
    p = exp_pkt[c];
    exp_pkt[c] = p + 1;
    for (int i = 0; i < HDR; i++) sb.push_back({(i == 0) ? 1'b1 : 1'b0, 1'b0, 8'(128 + 16 * c + i)});
    for (int k = 0; k < PKT; k++) sb.push_back({1'b0, (k == 0) ? 1'b1 : 1'b0, pay_byte(c, p, k, bad_ch, bad_pkt)});
  endtask

  task automatic run_monitor();
    logic [9:0] e;
    forever begin
      @(negedge SYS_CLK);
      cyc++;
      if (!RST) begin
        prev_bad = 1'b0;
        continue;
      end
      n_cmp++;
      if (sync_err !== prev_bad) begin
        n_err++;
        $display("FAIL sync_err: got %0b, expected %0b at cycle %0d", sync_err, prev_bad, cyc);
      end
      if (sync_err === 1'b1) serr_cnt++;
      prev_bad = 1'b0;
      n_cmp++;
      if (!(rd_req === 4'b0000 || (out_ready === 1'b1 && $onehot(rd_req)))) begin
        n_err++;
        $display("FAIL rd_req_rule: got rd_req=%b out_ready=%b, expected zero or one-hot with ready", rd_req, out_ready);
      end
      for (int c = 0; c < 4; c++) if (rd_req[c]) rd_cnt[c]++;
      if (d_valid) vcnt++;
      if (d_valid && out_ready) begin
        if (sop) sop_cyc.push_back(cyc);
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: got unexpected byte %02h, expected no transfer", data_out);
        end else begin
          e = sb.pop_front();
          if ({sop, psync, data_out} !== e) begin
            n_err++;
            $display("FAIL sb_data: got sop=%b psync=%b data=%02h, expected sop=%b psync=%b data=%02h",
                     sop, psync, data_out, e[9], e[8], e[7:0]);
          end
          if (e[8] && e[7:0] != 8'h47) prev_bad = 1'b1;
        end
      end
    end
  endtask

  task automatic reset_dut();
    @(posedge SYS_CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge SYS_CLK);
    #1 RST = 1'b1;
  endtask

  task automatic wait_sops(input int n, input int budget);
    int i;
    i = 0;
    while (sop_cyc.size() < n && i < budget) begin
      @(negedge SYS_CLK);
      i++;
    end
    n_cmp++;
    if (sop_cyc.size() < n) begin
      n_err++;
      $display("FAIL sop_wait: got %0d SOPs, expected %0d", sop_cyc.size(), n);
    end
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(negedge SYS_CLK);
      i++;
    end
    repeat (3) @(negedge SYS_CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d bytes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    @(negedge SYS_CLK);
    n_cmp++;
    if ({state_mon, d_valid, data_out, rd_req, sop, psync, sync_err, hdr_addr} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_a: got %h, expected 0", {state_mon, d_valid, data_out, rd_req, sop, psync, sync_err, hdr_addr});
    end
    n_cmp++;
    if ({state_mon_b, d_valid_b, data_out_b, rd_req_b, sop_b, psync_b, sync_err_b, hdr_addr_b} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_b: got %h, expected 0", {state_mon_b, d_valid_b, data_out_b, rd_req_b, sop_b, psync_b, sync_err_b, hdr_addr_b});
    end
    #1 RST = 1'b1;
    repeat (2) @(negedge SYS_CLK);
    n_cmp++;
    if ({state_mon, d_valid, rd_req} !== 7'h0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h, expected 0", {state_mon, d_valid, rd_req});
    end
  endtask

  task automatic test_single();
    int r2, v0;
    reset_dut();
    r2 = rd_cnt[2];
    v0 = vcnt;
    @(posedge SYS_CLK); #1;
    got = 4'b0100;
    push_pkt(2);
    @(negedge SYS_CLK);
    n_cmp++;
    if (state_mon !== 2'd0) begin
      n_err++;
      $display("FAIL grant_idle: got state %0d, expected 0", state_mon);
    end
    @(negedge SYS_CLK);
    n_cmp++;
    if ({state_mon, sop, data_out, hdr_addr} !== {2'd1, 1'b1, 8'hA0, 4'b1000}) begin
      n_err++;
      $display("FAIL grant_latency: got state=%0d sop=%b data=%02h addr=%h, expected 1 1 a0 8",
               state_mon, sop, data_out, hdr_addr);
    end
    @(posedge SYS_CLK); #1;
    got = 4'b0000;
    wait_drain(400);
    n_cmp++;
    if (rd_cnt[2] - r2 != PKT || vcnt - v0 != HDR + PKT) begin
      n_err++;
      $display("FAIL single_counts: got rd=%0d valid=%0d, expected %0d %0d", rd_cnt[2] - r2, vcnt - v0, PKT, HDR + PKT);
    end
    n_cmp++;
    if (state_mon !== 2'd0 || d_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_end: got state=%0d valid=%b, expected 0 0", state_mon, d_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    reset_dut();
    n0 = sop_cyc.size();
    @(posedge SYS_CLK); #1;
    got = 4'b1111;
    push_pkt(0); push_pkt(1); push_pkt(2); push_pkt(3); push_pkt(0);
    wait_sops(n0 + 5, 1200);
    @(posedge SYS_CLK); #1;
    got = 4'b0000;
    wait_drain(400);
    for (int k = 0; k < 4; k++) begin
      if (sop_cyc.size() >= n0 + k + 2) begin
        n_cmp++;
        if (sop_cyc[n0 + k + 1] - sop_cyc[n0 + k] != HDR + PKT + 1) begin
          n_err++;
          $display("FAIL rr_period: got %0d cycles, expected %0d", sop_cyc[n0 + k + 1] - sop_cyc[n0 + k], HDR + PKT + 1);
        end
      end
    end
  endtask

  task automatic test_mask();
    int n0, r1, r3;
    reset_dut();
    n0 = sop_cyc.size();
    r1 = rd_cnt[1];
    r3 = rd_cnt[3];
    @(posedge SYS_CLK); #1;
    en  = 4'b0111;
    got = 4'b1010;
    push_pkt(1); push_pkt(1); push_pkt(3);
    wait_sops(n0 + 2, 600);
    @(posedge SYS_CLK); #1;
    en = 4'b1111;
    n_cmp++;
    if (rd_cnt[3] != r3) begin
      n_err++;
      $display("FAIL masked_read: got %0d ch3 reads, expected 0", rd_cnt[3] - r3);
    end
    wait_sops(n0 + 3, 600);
    @(posedge SYS_CLK); #1;
    got = 4'b0000;
    wait_drain(400);
    n_cmp++;
    if (rd_cnt[3] - r3 != PKT || rd_cnt[1] - r1 != 2 * PKT) begin
      n_err++;
      $display("FAIL mask_counts: got ch1=%0d ch3=%0d, expected %0d %0d", rd_cnt[1] - r1, rd_cnt[3] - r3, 2 * PKT, PKT);
    end
  endtask

  task automatic test_backpressure();
    int n0, r0;
    reset_dut();
    n0 = sop_cyc.size();
    r0 = rd_cnt[0];
    @(posedge SYS_CLK); #1;
    got = 4'b0001;
    push_pkt(0);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) begin
      @(posedge SYS_CLK); #1;
      out_ready = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      if (sop_cyc.size() > n0) got = 4'b0000;
    end
    out_ready = 1'b1;
    wait_drain(50);
    n_cmp++;
    if (rd_cnt[0] - r0 != PKT) begin
      n_err++;
      $display("FAIL bp_reads: got %0d, expected %0d", rd_cnt[0] - r0, PKT);
    end
  endtask

  task automatic test_sync_err();
    int n0, s0;
    reset_dut();
    n0 = sop_cyc.size();
    s0 = serr_cnt;
    bad_ch  = 0;
    bad_pkt = exp_pkt[0];
    @(posedge SYS_CLK); #1;
    got = 4'b0001;
    push_pkt(0); push_pkt(0);
    wait_sops(n0 + 2, 600);
    @(posedge SYS_CLK); #1;
    got = 4'b0000;
    wait_drain(400);
    n_cmp++;
    if (serr_cnt - s0 != 1) begin
      n_err++;
      $display("FAIL sync_pulses: got %0d, expected 1", serr_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    @(posedge SYS_CLK); #1;
    got = 4'b0001;
    push_pkt(0);
    for (int i = 0; i < 600 && sb.size() > PKT - 50; i++) @(negedge SYS_CLK);
    @(posedge SYS_CLK); #2;
    RST = 1'b0;
    got = 4'b0000;
    #1;
    n_cmp++;
    if ({state_mon, d_valid, data_out, rd_req, sop, psync, sync_err, hdr_addr} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_mid: got %h, expected 0", {state_mon, d_valid, data_out, rd_req, sop, psync, sync_err, hdr_addr});
    end
    sb.delete();
    repeat (2) @(posedge SYS_CLK);
    #1 RST = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    n_cmp++;
    if ({state_mon, d_valid, rd_req} !== 7'h0) begin
      n_err++;
      $display("FAIL reset_mid_idle: got %h, expected 0", {state_mon, d_valid, rd_req});
    end
  endtask

  task automatic test_params();
    int sops[$];
    int rd_at[$];
    int rdb;
    logic [1:0] exp_ch[4];
    exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd0;
    rdb = 0;
    reset_dut();
    @(posedge SYS_CLK); #1;
    got_b = 3'b111;
    for (int i = 0; i < 100 && sops.size() < 4; i++) begin
      @(negedge SYS_CLK);
      for (int c = 0; c < 3; c++) if (rd_req_b[c]) rdb++;
      n_cmp++;
      if (sync_err_b !== 1'b0) begin
        n_err++;
        $display("FAIL b_sync_err: got %b, expected 0", sync_err_b);
      end
      if (d_valid_b && sop_b) begin
        n_cmp++;
        if (hdr_addr_b[2:1] !== exp_ch[sops.size()] || data_out_b !== 8'(128 + 16 * int'(exp_ch[sops.size()]))) begin
          n_err++;
          $display("FAIL b_grant: got ch=%0d data=%02h, expected ch=%0d", hdr_addr_b[2:1], data_out_b, exp_ch[sops.size()]);
        end
        sops.push_back(i);
        rd_at.push_back(rdb);
      end
    end
    @(posedge SYS_CLK); #1;
    got_b = 3'b000;
    n_cmp++;
    if (sops.size() != 4 || sops[0] != 1) begin
      n_err++;
      $display("FAIL b_sops: got %0d SOPs, first at %0d, expected 4 first at 1", sops.size(), (sops.size() > 0) ? sops[0] : -1);
    end
    for (int k = 0; k + 1 < sops.size(); k++) begin
      n_cmp++;
      if (sops[k + 1] - sops[k] != 13 || rd_at[k + 1] - rd_at[k] != 10) begin
        n_err++;
        $display("FAIL b_period: got %0d cycles %0d reads, expected 13 10", sops[k + 1] - sops[k], rd_at[k + 1] - rd_at[k]);
      end
    end
  endtask

  initial begin
    got = 4'b0000; en = 4'b1111; out_ready = 1'b1;
    got_b = 3'b000; en_b = 3'b111; ready_b = 1'b1;
    fork
      run_monitor();
      begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_backpressure();
        test_sync_err();
        test_reset_mid();
        test_params();
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ts_packet_mux.md
# ts_packet_mux

Parametrised N-channel transport-stream packet multiplexer. It arbitrates round-robin among per-channel packet buffers that hold a complete packet. For the granted channel it emits a per-channel header fetched from a header RAM, then streams the channel's payload bytes onto a single 8-bit output stream. Compared with the fixed 4-channel switch, it adds:

- configurable channel count, header length and payload length;
- single-cycle arbitration across all channels;
- downstream backpressure;
- a channel enable mask;
- sync-byte checking.

## Interface

Parameters:

- N_CH, default 4: number of source channels, 2..16. CW = max(1, clog2(N_CH)).
- HDR_BYTES, default 4: header bytes prepended per packet, 1..16. HW = max(1, clog2(HDR_BYTES)).
- PKT_BYTES, default 188: payload bytes read from the source per packet, 2..255.
- SYNC_BYTE, default 8'h47: expected first payload byte.

Ports:

- SYS_CLK, in, 1: clock, rising edge.
- RST, in, 1: reset, asynchronous, active-low.
- GOT_FULL_PACKET, in, N_CH: channel c buffer holds at least one full packet (level).
- CH_ENABLE, in, N_CH: channel c is eligible for arbitration when its bit is 1.
- DATA_IN_BUS, in, 8*N_CH: channel c byte on bits [8c+7:8c]; show-ahead FIFO output, valid whenever GOT_FULL_PACKET[c].
- HDR_ADDR, out, CW+HW: {channel, header byte index} into the header RAM.
- HDR_BYTE, in, 8: header RAM data, combinational from HDR_ADDR in the same cycle.
- RD_REQ, out, N_CH: one-hot FIFO read strobe; the byte on DATA_IN is consumed in that cycle.
- OUT_READY, in, 1: downstream accepts a byte this cycle.
- DATA_OUT, out, 8: output byte.
- D_VALID_OUT, out, 1: DATA_OUT valid. A transfer occurs when D_VALID_OUT && OUT_READY.
- SOP_OUT, out, 1: high with header byte 0.
- P_SYNC_OUT, out, 1: high with payload byte 0.
- SYNC_ERR, out, 1: one-cycle pulse when payload byte 0 is transferred with a value other than SYNC_BYTE.
- STATE_MON, out, 2: current state encoding.

## Operation

States, as STATE_MON encodings:

- IDLE (2'd0).
- HEADER (2'd1).
- PAYLOAD (2'd2).
- Encoding 2'd3 is illegal and returns to IDLE on the next clock.

IDLE:

- Eligible channel set E = GOT_FULL_PACKET & CH_ENABLE.
- Within one cycle, select the first set bit of E starting at rr_ptr and scanning upward with wrap (N_CH-1 wraps to 0).
- If E != 0: latch the selected channel into `chan`, clear the byte counter, go to HEADER.
- If E == 0: stay in IDLE.

HEADER:

- HDR_ADDR = {chan, idx}, with idx zero-extended to HW bits.
- DATA_OUT = HDR_BYTE; D_VALID_OUT = 1.
- idx advances only on a transfer.
- After the transfer of idx = HDR_BYTES-1, go to PAYLOAD with the counter cleared.

PAYLOAD:

- DATA_OUT = DATA_IN[chan].
- D_VALID_OUT = 1; RD_REQ[chan] = OUT_READY (combinational), so RD_REQ equals the transfer condition.
- On the transfer of payload byte PKT_BYTES-1: go to IDLE and set rr_ptr = chan+1 (mod N_CH).

Commitment rules:

- Once a channel is granted, the full packet is emitted.
- Changes of GOT_FULL_PACKET or CH_ENABLE during HEADER or PAYLOAD are ignored until the next IDLE.

Outputs outside HEADER/PAYLOAD:

- In IDLE: DATA_OUT = 0, D_VALID_OUT = 0, RD_REQ = 0, HDR_ADDR = {rr_ptr, 0}.

Sync check:

- Applies only to payload byte 0. The packet is still forwarded unchanged.
- SYNC_ERR is registered, asserting on the cycle after that transfer.

Counters:

- Byte counter width is 8 bits and never wraps within a packet.
- rr_ptr is CW bits. For non-power-of-2 N_CH, the increment wraps explicitly at N_CH-1.

## Timing

- Reset values:
  - state IDLE, rr_ptr 0, chan 0, counter 0, SYNC_ERR 0.
  - All combinational outputs follow from IDLE: RD_REQ 0, D_VALID_OUT 0, DATA_OUT 0, SOP_OUT 0, P_SYNC_OUT 0, STATE_MON 0.
- Grant latency: E becomes non-zero in cycle t (sampled in IDLE) → header byte 0 is on DATA_OUT in cycle t+1.
- With OUT_READY held high:
  - a packet occupies 1 + HDR_BYTES + PKT_BYTES cycles (193 at defaults);
  - D_VALID_OUT is high for HDR_BYTES + PKT_BYTES consecutive cycles;
  - exactly one IDLE cycle separates packets.
- OUT_READY low:
  - DATA_OUT, D_VALID_OUT, SOP_OUT/P_SYNC_OUT and the counter hold;
  - RD_REQ is 0, so no FIFO read occurs;
  - stalls of any length are legal in HEADER and PAYLOAD.
- Reset asserted mid-packet: immediate return to reset values. The partially read source packet is not recovered; upstream flushes.

## Test plan

- Single channel: N_CH=4, only ch2 full, OUT_READY=1, header RAM ch2 = 0xA0..0xA3, payload 0x47,1..187 → SOP, A0 A1 A2 A3, P_SYNC with 0x47, 188 RD_REQ[2] pulses, 192 valid bytes, then IDLE.
- Round-robin fairness: all four channels permanently full → grant order 0,1,2,3,0; 193-cycle packet period; RD_REQ never multi-hot.
- Skip and mask: only ch1 and ch3 full, CH_ENABLE=4'b0111 → only ch1 served repeatedly; ch3 is never read. Setting CH_ENABLE[3] mid-packet → ch3 is granted at the next IDLE.
- Backpressure: OUT_READY toggled pseudo-randomly during header and payload → output byte sequence is identical to the no-stall case; RD_REQ count = 188; no RD_REQ while OUT_READY = 0.
- Sync error: payload byte 0 = 0x46 → one SYNC_ERR pulse the cycle after the transfer; packet still forwarded in full. Next good packet → no pulse.
- Reset and parameters: RST low after 50 payload bytes → all outputs are at reset values immediately. Rerun with N_CH=3, HDR_BYTES=2, PKT_BYTES=10 → rr_ptr wraps 2→0; 13-cycle packet period.
